// File: rtl/fetch_stage_ibuf.sv
// fetch_stage_ibuf: instruction-fetch stage with a request/response SRAM-like
// interface, up to MAX_OUTSTANDING accepted fetches and an IBUF_DEPTH-entry
// instruction buffer that feeds decode in program order.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   flush_valid/flush_target      writeback redirect (wins over branch)
//   br_taken/br_target            branch redirect
//   ds_allowin                    decode can take the head entry
//   fs_to_ds_valid/fs_to_ds_bus   head entry {esubcode, ecode[5:0], ex, inst, pc}
//   inst_sram_*                   SRAM-like instruction port (read only)
//   fetch_cnt, discard_cnt        performance counters, present only when
//                                 IF_PERF_CNT_EN is defined
module fetch_stage_ibuf #(
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_valid,
  input  logic [31:0] flush_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [71:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] discard_cnt
`endif
);

  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int BW = $clog2(IBUF_DEPTH);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [IW-1:0] MAX_OUT   = IW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(IBUF_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(IBUF_DEPTH);
  localparam logic [PW-1:0] PEND_LAST = PW'(MAX_OUTSTANDING - 1);

  localparam logic [5:0]  ECODE_ADE     = 6'h08;
  localparam logic        ESUBCODE_ADEF = 1'b0;
  localparam logic [31:0] ADEF_INST     = 32'h00100000;

  logic [31:0]   pf_pc_reg;
  logic          req_pending_reg;
  logic          req_stale_reg;
  logic [31:0]   req_addr_reg;
  logic [31:0]   pend_pc_reg [MAX_OUTSTANDING];
  logic [PW-1:0] pend_wr_reg;
  logic [PW-1:0] pend_rd_reg;
  logic [IW-1:0] inflight_reg;
  logic [IW-1:0] discard_reg;
  logic [71:0]   ibuf_reg [IBUF_DEPTH];
  logic [BW-1:0] head_reg;
  logic [BW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic          adef_stall_reg;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [CW:0]   occupancy;
  logic          issue_ok;
  logic          new_req;
  logic          accept;
  logic          resp;
  logic          drop;
  logic          push_data;
  logic          adef_push;
  logic          push;
  logic          pop;
  logic          pend_after;
  logic [71:0]   push_entry;
  logic [IW-1:0] discard_redirect;

  assign redirect    = flush_valid | br_taken;
  assign redirect_pc = flush_valid ? flush_target : br_target;

  // Reserve a buffer slot for every word in flight so data_ok never stalls.
  assign occupancy = (CW+1)'(inflight_reg) + (CW+1)'(count_reg);
  assign issue_ok  = !adef_stall_reg && (pf_pc_reg[1:0] == 2'b00) &&
                     (inflight_reg < MAX_OUT) && (occupancy < DEPTH_OCC);

  // A fresh request never starts in a redirect cycle (it would fetch the old
  // path); a held request stays up until accepted.
  assign new_req         = !req_pending_reg && issue_ok && !redirect;
  assign inst_sram_req   = !reset && (req_pending_reg || new_req);
  assign inst_sram_addr  = req_pending_reg ? req_addr_reg : pf_pc_reg;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  assign accept     = inst_sram_req && inst_sram_addr_ok;
  assign pend_after = inst_sram_req && !inst_sram_addr_ok;
  assign resp       = inst_sram_data_ok && (inflight_reg != '0);
  assign drop       = resp && (redirect || (discard_reg != '0));
  assign push_data  = resp && !drop;

  assign fs_to_ds_valid = !reset && (count_reg != '0) && !redirect;
  assign fs_to_ds_bus   = (count_reg != '0) ? ibuf_reg[head_reg] : 72'h0;
  assign pop            = fs_to_ds_valid && ds_allowin;

  // Misaligned fetch PC: emit one exception entry once the memory side has
  // drained, then hold until a redirect.
  assign adef_push = !redirect && !adef_stall_reg && (pf_pc_reg[1:0] != 2'b00) &&
                     (inflight_reg == '0) && !req_pending_reg &&
                     ((count_reg != DEPTH_CNT) || pop);
  assign push = push_data || adef_push;

  assign push_entry = adef_push ?
      {ESUBCODE_ADEF, ECODE_ADE, 1'b1, ADEF_INST, pf_pc_reg} :
      {1'b0, 6'd0, 1'b0, inst_sram_rdata, pend_pc_reg[pend_rd_reg]};

  // Every word still owed by memory after a redirect belongs to the old path.
  assign discard_redirect = inflight_reg + IW'(accept) + IW'(pend_after) - IW'(resp);

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_pc_reg       <= RESET_PC;
      req_pending_reg <= 1'b0;
      req_stale_reg   <= 1'b0;
      req_addr_reg    <= 32'h0;
      pend_wr_reg     <= '0;
      pend_rd_reg     <= '0;
      inflight_reg    <= '0;
      discard_reg     <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      adef_stall_reg  <= 1'b0;
    end else begin
      req_pending_reg <= pend_after;
      req_stale_reg   <= pend_after && (req_stale_reg || redirect);
      if (inst_sram_req) req_addr_reg <= inst_sram_addr;

      // A stale held request must not advance the new-path PC.
      if (redirect) pf_pc_reg <= redirect_pc;
      else if (accept && !req_stale_reg) pf_pc_reg <= pf_pc_reg + 32'd4;

      if (accept) pend_wr_reg <= (pend_wr_reg == PEND_LAST) ? '0 : pend_wr_reg + PW'(1);
      if (resp)   pend_rd_reg <= (pend_rd_reg == PEND_LAST) ? '0 : pend_rd_reg + PW'(1);
      inflight_reg <= inflight_reg + IW'(accept) - IW'(resp);

      if (redirect) discard_reg <= discard_redirect;
      else if (resp && (discard_reg != '0)) discard_reg <= discard_reg - IW'(1);

      if (redirect) begin
        head_reg       <= '0;
        tail_reg       <= '0;
        count_reg      <= '0;
        adef_stall_reg <= 1'b0;
      end else begin
        if (push) tail_reg <= tail_reg + BW'(1);
        if (pop)  head_reg <= head_reg + BW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
        if (adef_push) adef_stall_reg <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (accept) pend_pc_reg[pend_wr_reg] <= inst_sram_addr;
  end

  always_ff @(posedge clk) begin
    if (push) ibuf_reg[tail_reg] <= push_entry;
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] discard_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_reg   <= 32'h0;
      discard_cnt_reg <= 32'h0;
    end else begin
      if (pop)  fetch_cnt_reg   <= fetch_cnt_reg + 32'd1;
      if (drop) discard_cnt_reg <= discard_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt   = fetch_cnt_reg;
  assign discard_cnt = discard_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage_ibuf.sv
module tb_fetch_stage_ibuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_valid;
  logic [31:0] flush_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [71:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  always #5 clk = ~clk;

  fetch_stage_ibuf #(
    .IBUF_DEPTH(4),
    .MAX_OUTSTANDING(2),
    .RESET_PC(32'h1c000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush_valid(flush_valid),
    .flush_target(flush_target),
    .br_taken(br_taken),
    .br_target(br_target),
    .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req),
    .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  // memory model: in-order responses, lat cycles after acceptance
  logic [31:0] mq_addr [$];
  int          mq_due [$];
  int          lat = 1;
  logic        aok_en = 1'b1;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          req_seen = 0;
  logic [71:0] got_q [$];
  int          got_cyc [$];

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]};
  endfunction

  function automatic logic [71:0] ent(input logic [31:0] pc);
    return {1'b0, 6'd0, 1'b0, inst_of(pc), pc};
  endfunction

  task automatic check_got(input string tag, input int idx, input logic [71:0] exp);
    logic [71:0] obs;
    obs = (idx < got_q.size()) ? got_q[idx] : 72'h0;
    check_val(tag, obs, exp);
  endtask

  // One clock cycle; called in the low phase after inputs are set.
  task automatic tick();
    inst_sram_addr_ok = aok_en;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = inst_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end
    #1;
    if (fs_to_ds_valid && ds_allowin) begin
      got_q.push_back(fs_to_ds_bus);
      got_cyc.push_back(cyc);
      $display("deliver cyc=%0d pc=%h inst=%h ex=%0d", cyc, fs_to_ds_bus[31:0],
               fs_to_ds_bus[63:32], fs_to_ds_bus[64]);
    end
    if (inst_sram_req) req_seen++;
    if (inst_sram_req && inst_sram_addr_ok) begin
      mq_addr.push_back(inst_sram_addr);
      mq_due.push_back(cyc + lat);
      acc_cnt++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_valid = 1'b0;
    br_taken = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    tick();
    tick();
    reset = 1'b0;
    got_q.delete();
    got_cyc.delete();
    acc_cnt = 0;
    req_seen = 0;
  endtask

  int start_cyc;
  int rcyc;

  initial begin
    reset = 1'b1;
    flush_valid = 1'b0;
    flush_target = 32'h0;
    br_taken = 1'b0;
    br_target = 32'h0;
    ds_allowin = 1'b1;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0;
    @(negedge clk);

    // reset state
    tick();
    tick();
    #1;
    check_val("rst_valid", fs_to_ds_valid, 0);
    check_val("rst_req", inst_sram_req, 0);
    check_val("rst_bus", fs_to_ds_bus, 0);
    reset = 1'b0;
    #1;
    check_val("first_req", inst_sram_req, 1);
    check_val("first_addr", inst_sram_addr, 32'h1c000000);
    check_val("size_word", inst_sram_size, 2'b10);

    // basic zero-wait fetch
    lat = 1;
    start_cyc = cyc;
    repeat (14) tick();
    for (int i = 0; i < 8; i++)
      check_got($sformatf("basic_%0d", i), i, ent(32'h1c000000 + 32'(4 * i)));
    check_val("basic_first_lat", (got_cyc.size() > 0) ? got_cyc[0] - start_cyc : -1, 2);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("basic_b2b_%0d", i),
                (got_cyc.size() > i + 1) ? got_cyc[i+1] - got_cyc[i] : -1, 1);

    // backpressure
    ds_allowin = 1'b0;
    do_reset();
    repeat (10) tick();
    #1;
    check_val("bp_valid", fs_to_ds_valid, 1);
    check_val("bp_req_drop", inst_sram_req, 0);
    check_val("bp_accepts", acc_cnt, 4);
    check_val("bp_head_pc", fs_to_ds_bus[31:0], 32'h1c000000);
    ds_allowin = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 8; i++)
      check_got($sformatf("bp_rel_%0d", i), i, ent(32'h1c000000 + 32'(4 * i)));

    // redirect with two in flight, memory latency 3
    ds_allowin = 1'b0;
    lat = 3;
    do_reset();
    repeat (6) tick();
    br_taken = 1'b1;
    br_target = 32'h1c000100;
    ds_allowin = 1'b1;
    #1;
    check_val("redir_valid0", fs_to_ds_valid, 0);
    rcyc = cyc;
    tick();
    br_taken = 1'b0;
    repeat (15) tick();
    check_got("redir_pc0", 0, ent(32'h1c000100));
    check_got("redir_pc1", 1, ent(32'h1c000104));
    check_val("redir_min_lat", (got_cyc.size() > 0) ? (got_cyc[0] - rcyc >= 3) : 0, 1);

    // flush wins over branch
    lat = 1;
    do_reset();
    repeat (4) tick();
    got_q.delete();
    got_cyc.delete();
    flush_valid = 1'b1;
    flush_target = 32'h1c008000;
    br_taken = 1'b1;
    br_target = 32'h1c000200;
    #1;
    check_val("flush_valid0", fs_to_ds_valid, 0);
    rcyc = cyc;
    tick();
    flush_valid = 1'b0;
    br_taken = 1'b0;
    repeat (10) tick();
    check_got("flush_pc0", 0, ent(32'h1c008000));
    check_got("flush_pc1", 1, ent(32'h1c008004));
    check_val("flush_lat", (got_cyc.size() > 0) ? got_cyc[0] - rcyc : -1, 3);

    // unaccepted request held across a redirect, then discarded
    aok_en = 1'b0;
    do_reset();
    tick();
    br_taken = 1'b1;
    br_target = 32'h1c000300;
    #1;
    check_val("hold_addr_redir", inst_sram_addr, 32'h1c000000);
    tick();
    br_taken = 1'b0;
    #1;
    check_val("hold_req", inst_sram_req, 1);
    check_val("hold_addr", inst_sram_addr, 32'h1c000000);
    aok_en = 1'b1;
    repeat (10) tick();
    check_got("hold_pc0", 0, ent(32'h1c000300));
    check_got("hold_pc1", 1, ent(32'h1c000304));

    // misaligned branch target
    do_reset();
    repeat (3) tick();
    br_taken = 1'b1;
    br_target = 32'h1c000102;
    tick();
    br_taken = 1'b0;
    got_q.delete();
    got_cyc.delete();
    req_seen = 0;
    repeat (8) tick();
    check_val("adef_no_req", req_seen, 0);
    check_val("adef_count", got_q.size(), 1);
    check_got("adef_entry", 0, {1'b0, 6'h08, 1'b1, 32'h00100000, 32'h1c000102});
    flush_valid = 1'b1;
    flush_target = 32'h1c008000;
    tick();
    flush_valid = 1'b0;
    got_q.delete();
    got_cyc.delete();
    repeat (8) tick();
    check_got("adef_resume", 0, ent(32'h1c008000));

    // reset mid-stream
    ds_allowin = 1'b0;
    lat = 3;
    do_reset();
    repeat (7) tick();
    #1;
    check_val("mid_pre_valid", fs_to_ds_valid, 1);
    reset = 1'b1;
    mq_addr.delete();
    mq_due.delete();
    tick();
    #1;
    check_val("mid_valid", fs_to_ds_valid, 0);
    check_val("mid_req", inst_sram_req, 0);
    check_val("mid_bus", fs_to_ds_bus, 0);
    reset = 1'b0;
    ds_allowin = 1'b1;
    lat = 1;
    got_q.delete();
    got_cyc.delete();
    #1;
    check_val("mid_restart_addr", inst_sram_addr, 32'h1c000000);
    repeat (8) tick();
    check_got("mid_pc0", 0, ent(32'h1c000000));
    check_got("mid_pc1", 1, ent(32'h1c000004));

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
